// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and address-field helpers for the cache line responder.
// Every width in the cache is derived from the four geometry constants below.
package cache_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LINES  = 16;
  localparam int WPL    = 4;

  localparam int OFF_W  = $clog2(WPL);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [OFF_W-1:0]  off_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  function automatic tag_t get_tag(input addr_t addr);
    return addr[ADDR_W-1:IDX_W+OFF_W];
  endfunction

  function automatic idx_t get_idx(input addr_t addr);
    return addr[IDX_W+OFF_W-1:OFF_W];
  endfunction

  function automatic off_t get_off(input addr_t addr);
    return addr[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped storage: per-line tag and valid bit plus WPL data words per line.
// One registered write port (a data word and/or tag+valid), one combinational read port.
module cache_line_array
  import cache_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  word_we,
  input  logic  meta_we,
  input  idx_t  w_idx,
  input  off_t  w_off,
  input  data_t w_data,
  input  tag_t  w_tag,
  input  logic  w_valid,
  input  idx_t  r_idx,
  input  off_t  r_off,
  output tag_t  r_tag,
  output logic  r_valid,
  output data_t r_data
);

  logic [LINES-1:0] valid_q;
  tag_t             tag_q  [LINES];
  data_t            data_q [LINES*WPL];

  // NOTE: only the valid bits are reset; tags and data are plain storage with no
  // reset so they map onto RAM, and a cleared valid bit already hides their contents.
  always_ff @(posedge i_clk) begin
    if (meta_we) tag_q[w_idx] <= w_tag;
    if (word_we) data_q[{w_idx, w_off}] <= w_data;
  end

  // NOTE: sequential state is always assigned with <= so every register samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else if (meta_we) begin
      valid_q[w_idx] <= w_valid;
    end
  end

  assign r_tag   = tag_q[r_idx];
  assign r_valid = valid_q[r_idx];
  assign r_data  = data_q[{r_idx, r_off}];

endmodule

// File: rtl/cache_line_responder.sv
// Memory-side responder for the cache controller: lookup, line refill over a multi-beat
// req/ack burst, and write-through/no-allocate writes.
module cache_line_responder
  import cache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_modify,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_stall,
  output logic              o_wr_done,
  output logic              o_mem_req,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_e state_q, state_d;
  addr_t  addr_q;
  data_t  wdata_q;
  logic   wr_q;
  off_t   beat_q, beat_d;
  logic   wr_done_q, wr_done_d;
  logic   latch_en;

  logic   word_we, meta_we, w_valid;
  off_t   w_off;
  data_t  w_data;
  tag_t   r_tag;
  logic   r_valid;
  data_t  r_data;
  logic   hit;

  cache_line_array u_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .word_we (word_we),
    .meta_we (meta_we),
    .w_idx   (get_idx(addr_q)),
    .w_off   (w_off),
    .w_data  (w_data),
    .w_tag   (get_tag(addr_q)),
    .w_valid (w_valid),
    .r_idx   (get_idx(addr_q)),
    .r_off   (get_off(addr_q)),
    .r_tag   (r_tag),
    .r_valid (r_valid),
    .r_data  (r_data)
  );

  assign hit     = r_valid && (r_tag == get_tag(addr_q));
  assign o_hit   = hit;
  assign o_rdata = hit ? r_data : '0;

  // NOTE: every signal driven here gets a default before the case statement, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    wr_done_d = 1'b0;
    latch_en  = 1'b0;
    word_we   = 1'b0;
    meta_we   = 1'b0;
    w_valid   = 1'b0;
    w_off     = get_off(addr_q);
    w_data    = wdata_q;

    unique case (state_q)
      IDLE: begin
        // A refill request takes priority and leaves the latched address untouched.
        if (i_modify) begin
          state_d = FILL;
          beat_d  = '0;
          meta_we = 1'b1;
          w_valid = 1'b0;
        end else if (i_start) begin
          latch_en = 1'b1;
          if (i_wr) state_d = WRITE;
        end
      end
      FILL: begin
        if (i_mem_ack) begin
          word_we = 1'b1;
          w_off   = beat_q;
          w_data  = i_mem_rdata;
          beat_d  = beat_q + off_t'(1);
          if (beat_q == off_t'(WPL - 1)) begin
            meta_we = 1'b1;
            w_valid = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        if (i_mem_ack) begin
          word_we   = hit;
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      beat_q    <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      wr_done_q <= wr_done_d;
      if (latch_en) begin
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
        wr_q    <= i_wr;
      end
    end
  end

  // Memory port is decoded straight from the state register so a reset drops the request at once.
  always_comb begin
    o_stall     = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    unique case (state_q)
      FILL: begin
        o_stall    = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_addr = {get_tag(addr_q), get_idx(addr_q), beat_q};
      end
      WRITE: begin
        o_stall     = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_wr    = wr_q;
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign o_wr_done = wr_done_q;

endmodule

// File: tb/tb_cache_line_responder.sv
// Self-checking bench for cache_line_responder: directed scenarios followed by a random
// mix of lookups, refills and writes, all checked against a line/word-level cache model.
module tb_cache_line_responder;
  import cache_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_start, i_wr, i_modify, i_mem_ack;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata, i_mem_rdata;
  logic              o_hit, o_stall, o_wr_done, o_mem_req, o_mem_wr;
  logic [DATA_W-1:0] o_rdata, o_mem_wdata;
  logic [ADDR_W-1:0] o_mem_addr;

  cache_line_responder dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_wr        (i_wr),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_modify    (i_modify),
    .o_hit       (o_hit),
    .o_rdata     (o_rdata),
    .o_stall     (o_stall),
    .o_wr_done   (o_wr_done),
    .o_mem_req   (o_mem_req),
    .o_mem_wr    (o_mem_wr),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: main memory plus a direct-mapped cache tracked per line.
  logic [31:0] main_mem [int];
  bit          m_valid [LINES];
  int          m_tag   [LINES];
  logic [31:0] m_data  [LINES][WPL];
  int          cur_addr;

  function automatic logic [31:0] mem_rd(input int a);
    logic [31:0] x;
    x = a;
    if (main_mem.exists(a)) return main_mem[a];
    return 32'h5A00_0000 ^ (x * 32'h0001_0103);
  endfunction

  function automatic int m_idx(input int a); return (a / WPL) % LINES; endfunction
  function automatic int m_tg(input int a);  return a / (WPL * LINES);  endfunction

  function automatic bit exp_hit(input int a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tg(a));
  endfunction

  function automatic logic [31:0] exp_rdata(input int a);
    return exp_hit(a) ? m_data[m_idx(a)][a % WPL] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    cur_addr = 0;
  endtask

  task automatic do_lookup(input int a);
    i_start = 1'b1; i_wr = 1'b0; i_addr = ADDR_W'(a);
    tick();
    i_start = 1'b0;
    cur_addr = a;
    check("lookup_hit", 64'(o_hit), 64'(exp_hit(a)));
    check("lookup_rdata", 64'(o_rdata), 64'(exp_rdata(a)));
    check("lookup_req", 64'(o_mem_req), 64'd0);
  endtask

  // Refill the line of cur_addr; 'waits' idle cycles precede every ack.
  // With start_too, a conflicting write request is raised in the same cycle as i_modify.
  task automatic do_fill(input int waits, input bit start_too);
    int base;
    base = (cur_addr / WPL) * WPL;
    i_modify = 1'b1;
    if (start_too) begin
      i_start = 1'b1; i_wr = 1'b1; i_addr = ADDR_W'(cur_addr ^ 16'h0240); i_wdata = 32'hBAD0_BAD0;
    end
    tick();
    i_modify = 1'b0; i_start = 1'b0; i_wr = 1'b0;
    for (int b = 0; b < WPL; b++) begin
      for (int w = 0; w <= waits; w++) begin
        check("fill_req", 64'(o_mem_req), 64'd1);
        check("fill_stall", 64'(o_stall), 64'd1);
        check("fill_memwr", 64'(o_mem_wr), 64'd0);
        check("fill_addr", 64'(o_mem_addr), 64'(base + b));
        check("fill_hit_low", 64'(o_hit), 64'd0);
        if (w == waits) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = mem_rd(base + b);
        end
        tick();
        i_mem_ack = 1'b0;
        i_mem_rdata = $urandom;
      end
    end
    m_valid[m_idx(base)] = 1'b1;
    m_tag[m_idx(base)]   = m_tg(base);
    for (int k = 0; k < WPL; k++) m_data[m_idx(base)][k] = mem_rd(base + k);
    check("fill_done_stall", 64'(o_stall), 64'd0);
    check("fill_done_req", 64'(o_mem_req), 64'd0);
    check("fill_done_hit", 64'(o_hit), 64'(exp_hit(cur_addr)));
    check("fill_done_rdata", 64'(o_rdata), 64'(exp_rdata(cur_addr)));
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input int waits);
    i_start = 1'b1; i_wr = 1'b1; i_addr = ADDR_W'(a); i_wdata = d;
    tick();
    i_start = 1'b0; i_wr = 1'b0; i_wdata = $urandom;
    cur_addr = a;
    for (int w = 0; w <= waits; w++) begin
      check("wr_req", 64'(o_mem_req), 64'd1);
      check("wr_memwr", 64'(o_mem_wr), 64'd1);
      check("wr_addr", 64'(o_mem_addr), 64'(a));
      check("wr_wdata", 64'(o_mem_wdata), 64'(d));
      check("wr_stall", 64'(o_stall), 64'd1);
      check("wr_done_early", 64'(o_wr_done), 64'd0);
      if (w == waits) i_mem_ack = 1'b1;
      tick();
      i_mem_ack = 1'b0;
    end
    main_mem[a] = d;
    if (exp_hit(a)) m_data[m_idx(a)][a % WPL] = d;
    check("wr_done_pulse", 64'(o_wr_done), 64'd1);
    check("wr_done_stall", 64'(o_stall), 64'd0);
    check("wr_done_req", 64'(o_mem_req), 64'd0);
    tick();
    check("wr_done_clear", 64'(o_wr_done), 64'd0);
    check("wr_hit", 64'(o_hit), 64'(exp_hit(a)));
    check("wr_rdata", 64'(o_rdata), 64'(exp_rdata(a)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_wr = 1'b0; i_modify = 1'b0; i_mem_ack = 1'b0;
    i_addr = '0; i_wdata = '0; i_mem_rdata = '0;
    model_reset();
    for (int k = 0; k < WPL; k++) main_mem[16'h0010 + k] = 32'hA0 + k;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_hit", 64'(o_hit), 64'd0);
    check("rst_rdata", 64'(o_rdata), 64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_wr_done", 64'(o_wr_done), 64'd0);
    check("rst_req", 64'(o_mem_req), 64'd0);
    check("rst_memwr", 64'(o_mem_wr), 64'd0);
    check("rst_memaddr", 64'(o_mem_addr), 64'd0);
    check("rst_memwdata", 64'(o_mem_wdata), 64'd0);

    // Cold miss, then zero-wait refill of 0x0010..0x0013
    do_lookup(16'h0012);
    do_fill(0, 1'b0);
    check("t2_rdata_a2", 64'(o_rdata), 64'hA2);

    // An ack while idle must be ignored
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    check("idle_ack_req", 64'(o_mem_req), 64'd0);
    check("idle_ack_stall", 64'(o_stall), 64'd0);
    check("idle_ack_hit", 64'(o_hit), 64'd1);

    // Refill with two wait cycles per beat
    do_lookup(16'h0125);
    do_fill(2, 1'b0);

    // Write hit with delayed ack, then read back; write miss stays unallocated
    do_write(16'h0011, 32'h0000_DEAD, 3);
    do_lookup(16'h0011);
    check("t4_readback", 64'(o_rdata), 64'hDEAD);
    do_write(16'h0150, 32'h1234_5678, 1);
    check("t4_miss_hit", 64'(o_hit), 64'd0);

    // Reset during beat 2 of a refill
    do_lookup(16'h0232);
    i_modify = 1'b1;
    tick();
    i_modify = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_mem_ack = 1'b1; i_mem_rdata = mem_rd(16'h0230 + b);
      tick();
    end
    i_mem_ack = 1'b0;
    check("t5_beat2_addr", 64'(o_mem_addr), 64'h0232);
    i_rst_n = 1'b0;
    #1;
    check("t5_async_req", 64'(o_mem_req), 64'd0);
    check("t5_async_stall", 64'(o_stall), 64'd0);
    model_reset();
    tick();
    i_rst_n = 1'b1;
    tick();
    do_lookup(16'h0232);
    do_lookup(16'h0012);

    // i_modify beats a same-cycle i_start; then index-3 conflict eviction
    do_lookup(16'h000C);
    do_fill(1, 1'b1);
    check("t6_start_ignored_hit", 64'(o_hit), 64'd1);
    do_lookup(16'h010E);
    check("t6_b_miss", 64'(o_hit), 64'd0);
    do_fill(0, 1'b0);
    do_lookup(16'h000D);
    check("t6_a_evicted", 64'(o_hit), 64'd0);
    do_lookup(16'h010F);
    check("t6_b_hit", 64'(o_hit), 64'd1);

    // Random mix over a few tags so hits, misses and evictions all occur
    for (int n = 0; n < 60; n++) begin
      int a;
      int op;
      a = ($urandom_range(0, 2) * WPL * LINES) + ($urandom_range(0, LINES - 1) * WPL)
          + $urandom_range(0, WPL - 1);
      op = $urandom_range(0, 2);
      do_lookup(a);
      if (op == 0) do_fill($urandom_range(0, 2), 1'(($urandom_range(0, 3) == 0)));
      else if (op == 1) do_write(a, $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
